// File: rtl/box_resampler.sv
// Nearest-neighbour resampler: reads a boxed region of the frame RAM
// and streams an OUT_DIM x OUT_DIM greyscale grid over valid/ready.
module box_resampler #(
  parameter int         WIDTH    = 100,
  parameter int         HEIGHT   = 100,
  parameter int         OUT_LOG2 = 4,
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] WHITE    = 8'd255
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       box,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              done
);

  localparam logic [7:0] XLIM = 8'(WIDTH - 1);
  localparam logic [7:0] YLIM = 8'(HEIGHT - 1);
  localparam logic [OUT_LOG2-1:0] IMAX = '1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, EMIT, EMPTY, DONE
  } state_t;

  state_t state, state_n;
  logic [7:0] xmin, xmax, ymin, ymax;
  logic [7:0] xmin_n, xmax_n, ymin_n, ymax_n;
  logic [OUT_LOG2-1:0] i, j, i_n, j_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [7:0] out_data_n;
  logic rd_en_n, out_valid_n, out_last_n, busy_n, done_n;
  logic [7:0] in_xmax, in_ymax, w, h;
  logic in_empty, last;

  function automatic logic [ADDR_W-1:0] src_addr(
    input logic [7:0] x0, input logic [7:0] bw,
    input logic [7:0] y0, input logic [7:0] bh,
    input logic [OUT_LOG2-1:0] ci,
    input logic [OUT_LOG2-1:0] cj
  );
    logic [15:0] px, py;
    logic [7:0] sx, sy;
    // full 16-bit products so the shift sees every bit
    px = 16'(ci) * 16'(bw);
    py = 16'(cj) * 16'(bh);
    sx = x0 + px[OUT_LOG2 +: 8];
    sy = y0 + py[OUT_LOG2 +: 8];
    return ADDR_W'(sy) * ADDR_W'(WIDTH) + ADDR_W'(sx);
  endfunction

  assign in_xmax  = (box[23:16] > XLIM) ? XLIM : box[23:16];
  assign in_ymax  = (box[7:0] > YLIM) ? YLIM : box[7:0];
  assign in_empty = (box[31:24] > in_xmax) || (box[15:8] > in_ymax);
  assign w        = xmax - xmin + 8'd1;
  assign h        = ymax - ymin + 8'd1;
  assign last     = (i == IMAX) && (j == IMAX);

  always_comb begin
    state_n     = state;
    xmin_n      = xmin;
    xmax_n      = xmax;
    ymin_n      = ymin;
    ymax_n      = ymax;
    i_n         = i;
    j_n         = j;
    rd_addr_n   = rd_addr;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    unique case (state)
      IDLE: if (start) begin
        xmin_n = box[31:24];
        xmax_n = in_xmax;
        ymin_n = box[15:8];
        ymax_n = in_ymax;
        i_n    = '0;
        j_n    = '0;
        if (in_empty) begin
          state_n     = EMPTY;
          out_valid_n = 1'b1;
          out_data_n  = WHITE;
          out_last_n  = (OUT_LOG2 == 0);
        end else begin
          state_n   = FETCH;
          rd_addr_n = src_addr(box[31:24], 8'd1,
                               box[15:8], 8'd1,
                               '0, '0);
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        out_data_n  = rd_data;
        out_valid_n = 1'b1;
        out_last_n  = last;
        state_n     = EMIT;
      end
      EMIT: if (out_ready) begin
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
        if (last) begin
          state_n = DONE;
        end else begin
          i_n = i + 1'b1;
          if (i == IMAX) j_n = j + 1'b1;
          state_n   = FETCH;
          rd_addr_n = src_addr(xmin, w, ymin, h, i_n, j_n);
        end
      end
      EMPTY: if (out_ready) begin
        if (last) begin
          state_n     = DONE;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
        end else begin
          i_n = i + 1'b1;
          if (i == IMAX) j_n = j + 1'b1;
          out_last_n = (i_n == IMAX) && (j_n == IMAX);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    rd_en_n = (state_n == FETCH);
    done_n  = (state_n == DONE);
    busy_n  = (state_n == FETCH) || (state_n == WAIT) ||
              (state_n == EMIT) || (state_n == EMPTY);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      xmin      <= '0;
      xmax      <= '0;
      ymin      <= '0;
      ymax      <= '0;
      i         <= '0;
      j         <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      xmin      <= xmin_n;
      xmax      <= xmax_n;
      ymin      <= ymin_n;
      ymax      <= ymax_n;
      i         <= i_n;
      j         <= j_n;
      rd_en     <= rd_en_n;
      rd_addr   <= rd_addr_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_box_resampler.sv
// Randomised scoreboard bench for box_resampler with a behavioural
// frame-RAM model and an arithmetic resample reference.
module tb_box_resampler;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] box;
  logic        busy;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;

  box_resampler dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .start    (start),
    .box      (box),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } pix_t;

  logic [7:0] mem [0:16383];
  int   exp_addr[$];
  pix_t exp_pix[$];
  int   obs_addr[0:255];
  int   rd_idx;
  int   hs_count;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;

  logic       stall_prev = 1'b0;
  logic       last_hs_prev = 1'b0;
  logic [7:0] pd;
  logic       pl;
  pix_t       mp;
  int         ma;

  always @(posedge CLOCK_50)
    if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference: plain integer arithmetic over the clamped box
  task automatic model_push(input logic [31:0] b);
    int x0, x1, y0, y1, bw, bh, sx, sy, a;
    pix_t p;
    x0 = int'(b[31:24]);
    x1 = int'(b[23:16]);
    y0 = int'(b[15:8]);
    y1 = int'(b[7:0]);
    if (x1 > 99) x1 = 99;
    if (y1 > 99) y1 = 99;
    bw = x1 - x0 + 1;
    bh = y1 - y0 + 1;
    for (int jj = 0; jj < 16; jj++)
      for (int ii = 0; ii < 16; ii++) begin
        p.l = (ii == 15) && (jj == 15);
        if (x0 > x1 || y0 > y1) begin
          p.d = 8'd255;
        end else begin
          sx = x0 + (ii * bw) / 16;
          sy = y0 + (jj * bh) / 16;
          a  = sy * 100 + sx;
          exp_addr.push_back(a);
          p.d = mem[a];
        end
        exp_pix.push_back(p);
      end
  endtask

  task automatic fill(input bit ident);
    for (int a = 0; a < 16384; a++) begin
      logic [13:0] av;
      av = 14'(a);
      mem[a] = ident ? av[7:0] : 8'($urandom);
    end
  endtask

  task automatic start_frame(input logic [31:0] b, input bit empty);
    @(posedge CLOCK_50); #1;
    rd_idx   = 0;
    hs_count = 0;
    model_push(b);
    box   = b;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_after_start", busy, 1);
    check(rd_en == !empty, "first_read", rd_en, !empty);
    if (!empty) begin
      repeat (2) @(posedge CLOCK_50);
      #1;
      check(out_valid == 1'b1, "first_valid", out_valid, 1);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 6000; k++) begin
      @(posedge CLOCK_50); #1;
      if (done) break;
    end
    check(k < 6000, "done_timeout", k, 6000);
    check(hs_count == 256, "handshakes", hs_count, 256);
  endtask

  initial forever begin
    @(posedge CLOCK_50); #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge CLOCK_50) begin
    if (reset_n && rd_en) begin
      if (exp_addr.size() == 0) begin
        check(1'b0, "unexpected_read", int'(rd_addr), -1);
      end else begin
        ma = exp_addr.pop_front();
        check(int'(rd_addr) == ma, "rd_addr", int'(rd_addr), ma);
      end
      if (rd_idx < 256) obs_addr[rd_idx] = int'(rd_addr);
      rd_idx++;
    end
  end

  always @(negedge CLOCK_50) begin
    if (!reset_n) begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (stall_prev)
        check(out_valid && out_data == pd && out_last == pl && !rd_en,
              "stall_hold", int'(out_data), int'(pd));
      if (last_hs_prev || done)
        check(done && last_hs_prev && !busy, "done_pulse",
              int'(done), int'(last_hs_prev));
      if (out_valid && out_ready) begin
        if (exp_pix.size() == 0) begin
          check(1'b0, "extra_pixel", int'(out_data), -1);
        end else begin
          mp = exp_pix.pop_front();
          check(out_data == mp.d, "out_data", int'(out_data), int'(mp.d));
          check(out_last == mp.l, "out_last", int'(out_last), int'(mp.l));
        end
        hs_count++;
      end
      stall_prev   = out_valid && !out_ready;
      last_hs_prev = out_valid && out_ready && out_last;
      pd = out_data;
      pl = out_last;
    end
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    box       = '0;
    out_ready = 1'b0;
    #1;
    check({busy, rd_en, out_valid, out_last, done} == 5'b0,
          "reset_ctrl", {busy, rd_en, out_valid, out_last, done}, 0);
    check(rd_addr == 0 && out_data == 0, "reset_data",
          int'(rd_addr), 0);
    repeat (3) @(posedge CLOCK_50);
    #2 reset_n = 1'b1;

    // full frame, always ready
    rdy_mode = 0; out_ready = 1'b1;
    fill(1'b0);
    start_frame(32'h0063_0063, 1'b0);
    wait_done();
    check(obs_addr[1] == 6, "full_px1", obs_addr[1], 6);
    check(obs_addr[16] == 600, "full_px16", obs_addr[16], 600);
    check(obs_addr[255] == 9393, "full_final", obs_addr[255], 9393);
    check(rd_idx == 256, "full_reads", rd_idx, 256);

    // identity box with random backpressure
    rdy_mode = 1;
    fill(1'b1);
    start_frame(32'h0A19_1423, 1'b0);
    wait_done();

    // empty box
    start_frame(32'h6300_6300, 1'b1);
    wait_done();
    check(rd_idx == 0, "empty_reads", rd_idx, 0);

    // single pixel box
    fill(1'b0);
    start_frame(32'h2828_2828, 1'b0);
    wait_done();
    check(obs_addr[200] == 4040, "single_addr", obs_addr[200], 4040);

    // explicit stall plus start while busy
    rdy_mode = 2; out_ready = 1'b1;
    start_frame(32'h0563_0A50, 1'b0);
    while (hs_count < 100) @(posedge CLOCK_50);
    #1 out_ready = 1'b0;
    box = 32'h0000_0000; start = 1'b1;
    @(posedge CLOCK_50); #1 start = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 out_ready = 1'b1;
    wait_done();

    // async reset mid-frame
    rdy_mode = 0;
    start_frame(32'h0350_0760, 1'b0);
    while (hs_count < 37) @(posedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    check({busy, rd_en, out_valid, out_last, done} == 5'b0,
          "midreset_ctrl", {busy, rd_en, out_valid, out_last, done}, 0);
    check(rd_addr == 0 && out_data == 0, "midreset_data",
          int'(rd_addr), 0);
    exp_addr.delete();
    exp_pix.delete();
    repeat (2) @(posedge CLOCK_50);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check(!rd_en && !busy, "idle_after_reset", {rd_en, busy}, 0);
    start_frame(32'h0A63_0063, 1'b0);
    wait_done();

    // random boxes, some clamped or empty
    rdy_mode = 1;
    for (int t = 0; t < 4; t++) begin
      logic [31:0] b;
      int x0, x1, y0, y1;
      bit e;
      b[31:24] = 8'($urandom_range(0, 99));
      b[23:16] = 8'($urandom_range(0, 255));
      b[15:8]  = 8'($urandom_range(0, 99));
      b[7:0]   = 8'($urandom_range(0, 255));
      x0 = int'(b[31:24]);
      x1 = (int'(b[23:16]) > 99) ? 99 : int'(b[23:16]);
      y0 = int'(b[15:8]);
      y1 = (int'(b[7:0]) > 99) ? 99 : int'(b[7:0]);
      e  = (x0 > x1) || (y0 > y1);
      fill(1'b0);
      start_frame(b, e);
      wait_done();
    end

    repeat (3) @(posedge CLOCK_50);
    check(exp_pix.size() == 0 && exp_addr.size() == 0, "queues_drained",
          exp_pix.size() + exp_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
